// File: rtl/jogo_seq_param.sv
// Memory game: plays back a growing button sequence, then checks the player's presses.
// Define JOGO_SEQ_LFSR_EN to draw sequence entries from a free-running LFSR instead of a fixed ramp.
module jogo_seq_param #(
    parameter int NBOT = 4,
    parameter int PROF = 16,
    parameter int TICK = 1000
) (
    input  logic                          clockFPGA,
    input  logic                          reset,
    input  logic                          jogar,
    input  logic [NBOT-1:0]               botoes,
    input  logic [1:0]                    nivel,
    input  logic [1:0]                    timeout_sel,
    output logic [NBOT-1:0]               leds,
    output logic                          ganhou,
    output logic                          perdeu,
    output logic                          pronto,
    output logic [$clog2(PROF+1)-1:0]     rodada,
    output logic [7:0]                    vitorias,
    output logic [7:0]                    derrotas,
    output logic [3:0]                    db_estado
);
    localparam int IW   = $clog2(NBOT);
    localparam int XW   = $clog2(PROF);
    localparam int RW   = $clog2(PROF+1);
    localparam int TW   = $clog2(10*TICK+1);
    localparam int HALF = (TICK/2 > 0) ? TICK/2 : 1;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        MOSTRA_ACESO   = 4'd2,
        MOSTRA_APAGADO = 4'd3,
        ESPERA         = 4'd4,
        COMPARA        = 4'd5,
        PROX_JOGADA    = 4'd6,
        PROX_RODADA    = 4'd7,
        GANHOU         = 4'd8,
        PERDEU         = 4'd9
    } state_t;

    state_t          state;
    logic [XW-1:0]   idx;
    logic [XW-1:0]   idx_inc;
    logic [TW-1:0]   cnt;
    logic [TW-1:0]   limit;
    logic [1:0]      nivel_q;
    logic [1:0]      tsel_q;
    logic [NBOT-1:0] press_q;
    logic [NBOT-1:0] botoes_prev;
    logic            jogar_prev;
    logic            press;
    logic            jogar_rise;
    logic [7:0]      idx_next;
    logic [7:0]      rod_ext;
    logic [7:0]      first_len;
    logic [7:0]      grow_len;
    logic [7:0]      first_clamp;
    logic [7:0]      grow_clamp;

    logic [IW-1:0]   seq_mem  [PROF];
    logic [IW-1:0]   fill_val [PROF];

    function automatic logic [NBOT-1:0] onehot(input logic [IW-1:0] e);
        return NBOT'(1) << e;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A press is the first non-zero sample after an all-zero sample, so a held button counts once.
    assign press      = (|botoes) && !(|botoes_prev);
    assign jogar_rise = jogar && !jogar_prev;
    assign db_estado  = state;

    assign idx_inc     = idx + XW'(1);
    assign idx_next    = 8'(idx) + 8'd1;
    assign rod_ext     = 8'(rodada);
    assign first_len   = 8'(nivel) + 8'd1;
    assign grow_len    = rod_ext + 8'(nivel_q) + 8'd1;
    assign first_clamp = (first_len >= 8'(PROF)) ? 8'(PROF) : first_len;
    assign grow_clamp  = (grow_len  >= 8'(PROF)) ? 8'(PROF) : grow_len;

    always_comb begin
        limit = '0;
        case (tsel_q)
            2'b01:   limit = TW'(10*TICK);
            2'b10:   limit = TW'(5*TICK);
            2'b11:   limit = TW'(2*TICK);
            default: limit = '0;
        endcase
    end

`ifdef JOGO_SEQ_LFSR_EN
    logic [15:0] lfsr;
    logic [15:0] walk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always_ff @(posedge clockFPGA) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= lfsr_next(lfsr);
    end

    // Each entry takes a successive LFSR state so a whole sequence is built in one cycle.
    always_comb begin
        walk = lfsr;
        for (int i = 0; i < PROF; i++) begin
            fill_val[i] = IW'(32'(walk) % NBOT);
            walk        = lfsr_next(walk);
        end
    end
`else
    always_comb begin
        for (int i = 0; i < PROF; i++) begin
            fill_val[i] = IW'(i % NBOT);
        end
    end
`endif

    always_ff @(posedge clockFPGA) begin
        if (state == PREPARA) begin
            for (int i = 0; i < PROF; i++) seq_mem[i] <= fill_val[i];
        end
    end

    always_ff @(posedge clockFPGA) begin
        if (!reset) begin
            state       <= INICIAL;
            idx         <= '0;
            cnt         <= '0;
            nivel_q     <= '0;
            tsel_q      <= '0;
            press_q     <= '0;
            botoes_prev <= '0;
            jogar_prev  <= 1'b0;
            leds        <= '0;
            ganhou      <= 1'b0;
            perdeu      <= 1'b0;
            pronto      <= 1'b0;
            rodada      <= '0;
            vitorias    <= '0;
            derrotas    <= '0;
        end else begin
            botoes_prev <= botoes;
            jogar_prev  <= jogar;
            case (state)
                INICIAL, GANHOU, PERDEU: begin
                    if (jogar_rise) begin
                        ganhou <= 1'b0;
                        perdeu <= 1'b0;
                        state  <= PREPARA;
                    end
                end
                PREPARA: begin
                    nivel_q <= nivel;
                    tsel_q  <= timeout_sel;
                    rodada  <= RW'(first_clamp);
                    idx     <= '0;
                    cnt     <= '0;
                    leds    <= onehot(fill_val[0]);
                    state   <= MOSTRA_ACESO;
                end
                MOSTRA_ACESO: begin
                    if (cnt == TW'(TICK-1)) begin
                        cnt   <= '0;
                        leds  <= '0;
                        state <= MOSTRA_APAGADO;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                MOSTRA_APAGADO: begin
                    if (cnt == TW'(HALF-1)) begin
                        cnt <= '0;
                        if (idx_next < rod_ext) begin
                            idx   <= idx_inc;
                            leds  <= onehot(seq_mem[idx_inc]);
                            state <= MOSTRA_ACESO;
                        end else begin
                            idx    <= '0;
                            pronto <= 1'b1;
                            state  <= ESPERA;
                        end
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                ESPERA: begin
                    leds <= botoes;
                    // Press is tested first so it beats a timeout landing on the same cycle.
                    if (press) begin
                        press_q <= botoes;
                        pronto  <= 1'b0;
                        state   <= COMPARA;
                    end else if (limit != '0 && cnt == limit - TW'(1)) begin
                        pronto   <= 1'b0;
                        perdeu   <= 1'b1;
                        derrotas <= sat_inc(derrotas);
                        leds     <= '0;
                        state    <= PERDEU;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                COMPARA: begin
                    leds <= botoes;
                    if (press_q == onehot(seq_mem[idx])) begin
                        state <= PROX_JOGADA;
                    end else begin
                        perdeu   <= 1'b1;
                        derrotas <= sat_inc(derrotas);
                        leds     <= '0;
                        state    <= PERDEU;
                    end
                end
                PROX_JOGADA: begin
                    leds <= botoes;
                    if (idx_next < rod_ext) begin
                        idx    <= idx_inc;
                        cnt    <= '0;
                        pronto <= 1'b1;
                        state  <= ESPERA;
                    end else begin
                        state <= PROX_RODADA;
                    end
                end
                PROX_RODADA: begin
                    if (rodada == RW'(PROF)) begin
                        ganhou   <= 1'b1;
                        vitorias <= sat_inc(vitorias);
                        leds     <= '0;
                        state    <= GANHOU;
                    end else begin
                        rodada <= RW'(grow_clamp);
                        idx    <= '0;
                        cnt    <= '0;
                        leds   <= onehot(seq_mem[0]);
                        state  <= MOSTRA_ACESO;
                    end
                end
                default: state <= INICIAL;
            endcase
        end
    end
endmodule

// File: tb/tb_jogo_seq_param.sv
// Bench for jogo_seq_param (NBOT=4, PROF=8, TICK=4, fixed-ramp sequence build).
module tb_jogo_seq_param;
    localparam int NBOT = 4;
    localparam int PROF = 8;
    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jogar = 1'b0;
    logic [3:0]  botoes = '0;
    logic [1:0]  nivel = '0;
    logic [1:0]  timeout_sel = '0;
    logic [3:0]  leds;
    logic        ganhou, perdeu, pronto;
    logic [3:0]  rodada;
    logic [7:0]  vitorias, derrotas;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;

    // playback events {rodada, leds} and end-of-game results {ganhou, perdeu, vitorias, derrotas, rodada}
    logic [7:0]  exp_q[$];
    logic [21:0] exp_res_q[$];

    jogo_seq_param #(.NBOT(NBOT), .PROF(PROF), .TICK(TICK)) dut (
        .clockFPGA  (clk),
        .reset      (rst_n),
        .jogar      (jogar),
        .botoes     (botoes),
        .nivel      (nivel),
        .timeout_sel(timeout_sel),
        .leds       (leds),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .pronto     (pronto),
        .rodada     (rodada),
        .vitorias   (vitorias),
        .derrotas   (derrotas),
        .db_estado  (db_estado)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every entry into playback or an end state is compared against the queues.
    logic [3:0] prev_st = 4'd0;
    always @(negedge clk) begin
        if (db_estado != prev_st) begin
            if (db_estado == 4'd2) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL playback_unexpected: got %0h expected none", {rodada, leds});
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if ({rodada, leds} !== e) begin
                        errors++;
                        $display("FAIL playback: got %0h expected %0h", {rodada, leds}, e);
                    end
                end
            end
            if (db_estado == 4'd8 || db_estado == 4'd9) begin
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got %0h expected none",
                             {ganhou, perdeu, vitorias, derrotas, rodada});
                end else begin
                    logic [21:0] r;
                    r = exp_res_q.pop_front();
                    if ({ganhou, perdeu, vitorias, derrotas, rodada} !== r) begin
                        errors++;
                        $display("FAIL result: got %0h expected %0h",
                                 {ganhou, perdeu, vitorias, derrotas, rodada}, r);
                    end
                end
            end
        end
        prev_st = db_estado;
    end

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << (i % NBOT);
    endfunction

    task automatic push_ev(input int r, input int i);
        exp_q.push_back({4'(r), oh(i)});
    endtask

    task automatic push_res(input logic g, input logic p, input int v, input int d, input int r);
        exp_res_q.push_back({g, p, 8'(v), 8'(d), 4'(r)});
    endtask

    task automatic start_game(input logic [1:0] nv, input logic [1:0] ts);
        nivel = nv;
        timeout_sel = ts;
        @(negedge clk);
        jogar = 1'b1;
        @(negedge clk);
        jogar = 1'b0;
    endtask

    task automatic wait_pronto();
        int n;
        n = 0;
        while (!pronto && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!pronto) begin
            errors++;
            $display("FAIL wait_pronto: got timeout after %0d cycles expected pronto=1", n);
        end
    endtask

    task automatic press(input logic [3:0] v);
        botoes = v;
        @(negedge clk);
        @(negedge clk);
        botoes = '0;
        @(negedge clk);
    endtask

    initial begin
        int r;
        int k;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_state", 32'(db_estado), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_counts", {16'd0, vitorias, derrotas}, 32'd0);
        check("rst_flags", {29'd0, ganhou, perdeu, pronto}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // game 1: nivel=1, every press correct -> rounds 2,4,6,8 then win
        r = 2;
        forever begin
            for (int i = 0; i < r; i++) push_ev(r, i);
            if (r == PROF) break;
            r = (r + 2 > PROF) ? PROF : r + 2;
        end
        push_res(1'b1, 1'b0, 1, 0, 8);
        start_game(2'd1, 2'd0);
        r = 2;
        forever begin
            for (int i = 0; i < r; i++) begin
                wait_pronto();
                press(oh(i));
            end
            if (r == PROF) break;
            r = (r + 2 > PROF) ? PROF : r + 2;
        end
        repeat (4) @(negedge clk);
        check("g1_ganhou", {31'd0, ganhou}, 32'd1);

        // game 2: wrong button in round 1; jogar during ESPERA ignored
        push_ev(1, 0);
        push_res(1'b0, 1'b1, 1, 1, 1);
        start_game(2'd0, 2'd0);
        wait_pronto();
        jogar = 1'b1;
        @(negedge clk);
        jogar = 1'b0;
        @(negedge clk);
        check("g2_jogar_ignored", 32'(db_estado), 32'd4);
        botoes = 4'b0010;
        @(negedge clk);
        check("g2_compara", 32'(db_estado), 32'd5);
        @(negedge clk);
        check("g2_perdeu_next", {27'd0, db_estado, perdeu}, {27'd0, 4'd9, 1'b1});
        botoes = '0;
        repeat (2) @(negedge clk);

        // game 3: timeout_sel=10 with no press -> lose 20 cycles after entering ESPERA
        push_ev(1, 0);
        push_res(1'b0, 1'b1, 1, 2, 1);
        start_game(2'd0, 2'b10);
        wait_pronto();
        k = 0;
        while (db_estado != 4'd9 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("g3_timeout_cycles", 32'(k), 32'd20);
        repeat (2) @(negedge clk);

        // game 4: held button spans into next ESPERA without a second press, then a two-bit press loses
        push_ev(1, 0);
        push_ev(2, 0);
        push_ev(2, 1);
        push_res(1'b0, 1'b1, 1, 3, 2);
        start_game(2'd0, 2'd0);
        wait_pronto();
        botoes = 4'b0001;
        repeat (30) @(negedge clk);
        check("g4_held_single", {27'd0, db_estado, pronto}, {27'd0, 4'd4, 1'b1});
        botoes = '0;
        @(negedge clk);
        botoes = 4'b0011;
        repeat (2) @(negedge clk);
        botoes = '0;
        check("g4_multi_bit_lose", 32'(db_estado), 32'd9);
        repeat (2) @(negedge clk);

        // game 5: reset pulse during playback
        push_ev(1, 0);
        start_game(2'd0, 2'd0);
        k = 0;
        while (db_estado != 4'd2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("g5_reach_aceso", 32'(db_estado), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("g5_rst_state", 32'(db_estado), 32'd0);
        check("g5_rst_leds", 32'(leds), 32'd0);
        check("g5_rst_counts", {16'd0, vitorias, derrotas}, 32'd0);
        check("g5_rst_rodada", 32'(rodada), 32'd0);
        repeat (5) @(negedge clk);

        check("ev_queue_drained", 32'(exp_q.size()), 32'd0);
        check("res_queue_drained", 32'(exp_res_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
